// File: rtl/lcd_line_writer.sv
// HD44780 8-bit line writer: powers up the LCD, then rewrites one 16-character
// line from line_ascii whenever the text differs from what was last shown.
module lcd_line_writer #(
   parameter int unsigned INIT_WAIT_CYC  = 750000,
   parameter int unsigned E_PULSE_CYC    = 25,
   parameter int unsigned CMD_WAIT_CYC   = 2500,
   parameter int unsigned CLEAR_WAIT_CYC = 100000,
   parameter logic [6:0]  LINE_ADDR      = 7'h00
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] line_ascii,
   output logic         lcd_e,
   output logic         lcd_rs,
   output logic         lcd_rw,
   output logic [7:0]   lcd_data,
   output logic         busy,
   output logic         done
);

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned CNT_MAX = max2(max2(INIT_WAIT_CYC, E_PULSE_CYC),
                                          max2(CMD_WAIT_CYC, CLEAR_WAIT_CYC));
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned N_INIT  = 4;
   localparam int unsigned N_CHAR  = 16;

   localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);
   localparam logic [IDX_W-1:0] INIT_IDX_LAST = IDX_W'(N_INIT - 1);
   localparam logic [IDX_W-1:0] CHAR_IDX_LAST = IDX_W'(N_CHAR - 1);

   typedef enum logic [2:0] {
      S_PWR_WAIT,
      S_INIT,
      S_IDLE,
      S_ADDR,
      S_CHAR,
      S_FIN
   } state_t;

   typedef enum logic [1:0] {
      PH_SETUP,
      PH_PULSE,
      PH_HOLD
   } phase_t;

   state_t             state;
   phase_t             phase;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   idx;
   logic               force_refresh;
   logic [127:0]       snap;
   logic [127:0]       shown;
   logic [CNT_W-1:0]   hold_last;
   logic               refresh_req;

   // Function set 8-bit/2-line, display on, entry increment, clear.
   function automatic logic [7:0] init_cmd(input logic [IDX_W-1:0] i);
      case (i)
         4'd0:    return 8'h38;
         4'd1:    return 8'h0C;
         4'd2:    return 8'h06;
         default: return 8'h01;
      endcase
   endfunction

   // Leftmost character first; unfilled (zero) positions are shown as spaces.
   function automatic logic [7:0] char_at(input logic [127:0] s, input logic [IDX_W-1:0] i);
      logic [7:0] c;
      c = s[8*(15 - int'(i)) +: 8];
      return (c == 8'h00) ? 8'h20 : c;
   endfunction

   always_comb begin
      hold_last = CMD_LAST;
      if (state == S_INIT && idx == INIT_IDX_LAST) begin
         hold_last = CLEAR_LAST;
      end
   end

   assign refresh_req = force_refresh || (line_ascii != shown);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_PWR_WAIT;
         phase         <= PH_SETUP;
         cnt           <= '0;
         idx           <= '0;
         force_refresh <= 1'b1;
         lcd_e         <= 1'b0;
         lcd_rs        <= 1'b0;
         lcd_rw        <= 1'b0;
         lcd_data      <= 8'h00;
         busy          <= 1'b1;
         done          <= 1'b0;
      end else begin
         lcd_rw <= 1'b0;
         done   <= 1'b0;
         case (state)
            S_PWR_WAIT: begin
               if (cnt == INIT_LAST) begin
                  cnt      <= '0;
                  idx      <= '0;
                  phase    <= PH_SETUP;
                  state    <= S_INIT;
                  lcd_rs   <= 1'b0;
                  lcd_data <= init_cmd('0);
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_INIT, S_ADDR, S_CHAR: begin
               case (phase)
                  PH_SETUP: begin
                     lcd_e <= 1'b1;
                     cnt   <= '0;
                     phase <= PH_PULSE;
                  end
                  PH_PULSE: begin
                     if (cnt == PULSE_LAST) begin
                        lcd_e <= 1'b0;
                        cnt   <= '0;
                        phase <= PH_HOLD;
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end
                  default: begin
                     if (cnt == hold_last) begin
                        cnt   <= '0;
                        phase <= PH_SETUP;
                        // Byte finished: load the next byte or leave the sequence.
                        case (state)
                           S_INIT: begin
                              if (idx == INIT_IDX_LAST) begin
                                 state <= S_IDLE;
                                 busy  <= 1'b0;
                              end else begin
                                 idx      <= idx + IDX_W'(1);
                                 lcd_data <= init_cmd(idx + IDX_W'(1));
                              end
                           end
                           S_ADDR: begin
                              state    <= S_CHAR;
                              idx      <= '0;
                              lcd_rs   <= 1'b1;
                              lcd_data <= char_at(snap, '0);
                           end
                           default: begin
                              if (idx == CHAR_IDX_LAST) begin
                                 state <= S_FIN;
                                 done  <= 1'b1;
                              end else begin
                                 idx      <= idx + IDX_W'(1);
                                 lcd_data <= char_at(snap, idx + IDX_W'(1));
                              end
                           end
                        endcase
                     end else begin
                        cnt <= cnt + CNT_W'(1);
                     end
                  end
               endcase
            end

            S_IDLE: begin
               if (refresh_req) begin
                  state         <= S_ADDR;
                  phase         <= PH_SETUP;
                  cnt           <= '0;
                  snap          <= line_ascii;
                  force_refresh <= 1'b0;
                  lcd_rs        <= 1'b0;
                  lcd_data      <= {1'b1, LINE_ADDR};
                  busy          <= 1'b1;
               end
            end

            S_FIN: begin
               shown <= snap;
               state <= S_IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= S_PWR_WAIT;
               phase <= PH_SETUP;
               cnt   <= '0;
               lcd_e <= 1'b0;
               busy  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_line_writer.sv
// Scoreboard bench for lcd_line_writer: expected LCD bytes are queued as
// stimulus is applied and popped on each lcd_e rising edge.
module tb_lcd_line_writer;

   localparam int unsigned INIT_W = 20;
   localparam int unsigned E_W    = 2;
   localparam int unsigned CMD_W  = 3;
   localparam int unsigned CLR_W  = 10;
   localparam int unsigned B      = 1 + E_W + CMD_W;
   localparam int unsigned INIT_EDGES = INIT_W + 3*B + (1 + E_W + CLR_W);

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] line_ascii = '0;
   logic         lcd_e, lcd_rs, lcd_rw, busy, done;
   logic [7:0]   lcd_data;

   int total = 0;
   int bad   = 0;

   logic [8:0] q[$];

   lcd_line_writer #(
      .INIT_WAIT_CYC (INIT_W),
      .E_PULSE_CYC   (E_W),
      .CMD_WAIT_CYC  (CMD_W),
      .CLEAR_WAIT_CYC(CLR_W),
      .LINE_ADDR     (7'h00)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .line_ascii(line_ascii),
      .lcd_e     (lcd_e),
      .lcd_rs    (lcd_rs),
      .lcd_rw    (lcd_rw),
      .lcd_data  (lcd_data),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_init();
      q.push_back({1'b0, 8'h38});
      q.push_back({1'b0, 8'h0C});
      q.push_back({1'b0, 8'h06});
      q.push_back({1'b0, 8'h01});
   endtask

   task automatic push_line(input logic [127:0] l);
      logic [7:0] c;
      q.push_back({1'b0, 8'h80});
      for (int i = 0; i < 16; i++) begin
         c = l[127 - 8*i -: 8];
         q.push_back({1'b1, (c == 8'h00) ? 8'h20 : c});
      end
   endtask

   task automatic wait_done(input string tag, input int budget, output int n);
      n = 0;
      while (n < budget) begin
         @(posedge clk); #1;
         n++;
         if (done) break;
      end
      if (!done) chk(tag, 32'(done), 32'd1);
   endtask

   // Bus monitor, sampled on the falling edge.
   logic       prev_e    = 1'b0;
   logic       prev_done = 1'b0;
   logic [8:0] prev_bus  = '0;
   logic [8:0] rise_bus  = '0;
   logic [8:0] exp_bus;
   bit         aborted   = 1'b0;
   int         width     = 0;
   int         rise_cnt  = 0;
   int         done_cnt  = 0;

   always @(negedge clk) begin
      chk("rw_low", 32'(lcd_rw), 32'd0);
      if (rst) aborted = 1'b1;
      if (lcd_e && !prev_e) begin
         rise_cnt++;
         width    = 1;
         aborted  = rst;
         rise_bus = {lcd_rs, lcd_data};
         chk("setup_stable", 32'({lcd_rs, lcd_data}), 32'(prev_bus));
         if (q.size() > 0) begin
            exp_bus = q.pop_front();
            chk("byte", 32'({lcd_rs, lcd_data}), 32'(exp_bus));
         end else begin
            chk("unexpected_byte", 32'(q.size()), 32'd1);
         end
      end else if (lcd_e) begin
         width++;
         chk("bus_stable", 32'({lcd_rs, lcd_data}), 32'(rise_bus));
      end else if (prev_e && !aborted) begin
         chk("e_width", 32'(width), 32'(E_W));
      end
      if (done) begin
         done_cnt++;
         chk("done_one_cycle", 32'(prev_done), 32'd0);
      end
      prev_e    = lcd_e;
      prev_bus  = {lcd_rs, lcd_data};
      prev_done = done;
   end

   initial begin
      int n;
      int base;
      int d0;
      bit e_seen;
      bit busy_seen;
      logic [127:0] nopo, dongnae, yeonsan, seomyeon;
      nopo     = {"Nopo", 96'h0};
      dongnae  = {"Dongnae", 72'h0};
      yeonsan  = {"Yeonsan", 72'h0};
      seomyeon = {"Seomyeon", 64'h0};

      // Reset state
      rst = 1'b1;
      line_ascii = nopo;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_e", 32'(lcd_e), 32'd0);
      chk("rst_rs", 32'(lcd_rs), 32'd0);
      chk("rst_data", 32'(lcd_data), 32'h00);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_done", 32'(done), 32'd0);

      // Power-up: init sequence, then forced write of "Nopo"
      push_init();
      push_line(nopo);
      rst = 1'b0;
      n = 0;
      while (n < 1000) begin
         @(posedge clk); #1;
         n++;
         if (!busy) break;
      end
      chk("init_edges", 32'(n), 32'(INIT_EDGES));
      @(posedge clk); #1;
      chk("force_addr_setup", 32'({lcd_e, lcd_rs, lcd_data}), 32'({1'b0, 1'b0, 8'h80}));
      chk("force_busy", 32'(busy), 32'd1);
      wait_done("pwr_done_timeout", 1000, n);
      chk("pwr_refresh_len", 32'(n), 32'(17*B));
      @(posedge clk); #1;
      chk("pwr_busy_low", 32'(busy), 32'd0);
      chk("pwr_done_cnt", 32'(done_cnt), 32'd1);
      chk("pwr_queue_empty", 32'(q.size()), 32'd0);

      // Change detect with minimum latency
      line_ascii = dongnae;
      push_line(dongnae);
      @(posedge clk); #1;
      chk("chg_addr_setup", 32'({lcd_e, lcd_rs, lcd_data}), 32'({1'b0, 1'b0, 8'h80}));
      chk("chg_busy", 32'(busy), 32'd1);
      wait_done("chg_done_timeout", 1000, n);
      chk("chg_refresh_len", 32'(n), 32'(17*B));
      @(posedge clk); #1;
      chk("chg_busy_low", 32'(busy), 32'd0);
      chk("chg_queue_empty", 32'(q.size()), 32'd0);

      // No change for 500 cycles
      e_seen = 1'b0;
      busy_seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #1;
         if (lcd_e) e_seen = 1'b1;
         if (busy) busy_seen = 1'b1;
      end
      chk("idle_e_quiet", 32'(e_seen), 32'd0);
      chk("idle_busy_low", 32'(busy_seen), 32'd0);
      chk("idle_done_cnt", 32'(done_cnt), 32'd2);

      // Mid-refresh change: "Yeonsan" completes, then "Seomyeon"
      base = rise_cnt;
      d0 = done_cnt;
      line_ascii = yeonsan;
      push_line(yeonsan);
      n = 0;
      while (rise_cnt < base + 6 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("mid_reach_char5", 32'(rise_cnt >= base + 6), 32'd1);
      line_ascii = seomyeon;
      push_line(seomyeon);
      wait_done("mid_done1_timeout", 1000, n);
      @(posedge clk); #1;
      chk("mid_first_done", 32'(done_cnt), 32'(d0 + 1));
      chk("mid_queue_after_first", 32'(q.size()), 32'd17);
      wait_done("mid_done2_timeout", 1000, n);
      @(posedge clk); #1;
      chk("mid_second_done", 32'(done_cnt), 32'(d0 + 2));
      chk("mid_queue_empty", 32'(q.size()), 32'd0);

      // Reset while lcd_e is high, then full init and forced rewrite
      base = rise_cnt;
      line_ascii = nopo;
      push_line(nopo);
      n = 0;
      while (!(rise_cnt >= base + 3 && lcd_e) && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rpulse_e_high", 32'(lcd_e), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rpulse_e_low", 32'(lcd_e), 32'd0);
      chk("rpulse_busy", 32'(busy), 32'd1);
      q.delete();
      push_init();
      push_line(nopo);
      d0 = done_cnt;
      @(posedge clk); #1;
      rst = 1'b0;
      n = 0;
      while (n < 1000) begin
         @(posedge clk); #1;
         n++;
         if (!busy) break;
      end
      chk("rpulse_init_edges", 32'(n), 32'(INIT_EDGES));
      wait_done("rpulse_done_timeout", 1000, n);
      @(posedge clk); #1;
      chk("rpulse_done_cnt", 32'(done_cnt), 32'(d0 + 1));
      chk("rpulse_queue_empty", 32'(q.size()), 32'd0);
      chk("rpulse_busy_low", 32'(busy), 32'd0);

      repeat (5) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
